// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
// The optional fair-arbitration build is selected with MEM_ARB_FAIR_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int WDOG_MAX_DEF = 64;

endpackage

// File: rtl/mem_arb_wdog.sv
// Access watchdog: cleared when an access is issued, counts while waiting for ack.
// expired fires on the waiting cycle whose increment would reach MAX.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int MAX = WDOG_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // wait-cycle counter, saturating at MAX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + ONE_C;
    end
  end

  assign expired = inc & (cnt_r == LAST_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and data (MEM) ports onto one variable-latency memory.
// Define MEM_ARB_FAIR_EN to alternate grants on contention instead of data-first priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  arb_state_e        state_r, next_state_s;
  logic              port_r;
  logic              mem_en_r, mem_wr_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] if_rdata_r, dm_rdata_r;
  logic              if_done_r, dm_done_r;
  logic              err_r;

  logic dm_req_s, if_cand_s, dm_cand_s;
  logic pick_s, grant_s, grant_err_s;
  logic ack_s, wdog_exp_s, timeout_s, finish_s;

  // A port completing this cycle is masked so its still-held request is not re-taken.
  assign dm_req_s  = dm_rd | dm_wr;
  assign if_cand_s = if_req & ~if_done_r;
  assign dm_cand_s = dm_req_s & ~dm_done_r;

  assign ack_s     = mem_ack & ((state_r == ISSUE) | (state_r == WAIT));
  assign timeout_s = wdog_exp_s & ~ack_s;
  assign finish_s  = ack_s | timeout_s;

`ifdef MEM_ARB_FAIR_EN
  logic last_grant_r;

  // remember which port won the previous grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= PORT_IF;
    end else if (grant_s) begin
      last_grant_r <= pick_s;
    end
  end

  // on contention the port not granted last wins
  always_comb begin
    pick_s = PORT_IF;
    if (dm_cand_s && if_cand_s) begin
      pick_s = ~last_grant_r;
    end else if (dm_cand_s) begin
      pick_s = PORT_DM;
    end else begin
      pick_s = PORT_IF;
    end
  end
`else
  // data port (older instruction) always beats fetch
  always_comb begin
    pick_s = PORT_IF;
    if (dm_cand_s) begin
      pick_s = PORT_DM;
    end else begin
      pick_s = PORT_IF;
    end
  end
`endif

  // next-state logic and grant strobe
  always_comb begin
    next_state_s = state_r;
    grant_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_cand_s || if_cand_s) begin
          grant_s      = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      WAIT: begin
        if (finish_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // illegal request shapes are flagged at grant; the access is still carried out
  always_comb begin
    grant_err_s = 1'b0;
    if (!grant_s) begin
      grant_err_s = 1'b0;
    end else if (pick_s == PORT_DM) begin
      grant_err_s = (dm_rd & dm_wr) | dm_addr[0];
    end else begin
      grant_err_s = if_addr[0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // latched access, memory strobe, completion pulses, read data and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_r      <= PORT_IF;
      mem_en_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= {DATA_W{1'b0}};
      dm_rdata_r  <= {DATA_W{1'b0}};
      if_done_r   <= 1'b0;
      dm_done_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_en_r  <= grant_s;
      if_done_r <= finish_s & (port_r == PORT_IF);
      dm_done_r <= finish_s & (port_r == PORT_DM);
      err_r     <= err_r | grant_err_s | timeout_s;
      if (grant_s) begin
        port_r <= pick_s;
        if (pick_s == PORT_DM) begin
          mem_addr_r  <= {dm_addr[ADDR_W-1:1], 1'b0};
          mem_wdata_r <= dm_wdata;
          mem_wr_r    <= dm_wr;
        end else begin
          mem_addr_r  <= {if_addr[ADDR_W-1:1], 1'b0};
          mem_wdata_r <= {DATA_W{1'b0}};
          mem_wr_r    <= 1'b0;
        end
      end
      if (ack_s && !mem_wr_r) begin
        if (port_r == PORT_DM) begin
          dm_rdata_r <= mem_rdata;
        end else begin
          if_rdata_r <= mem_rdata;
        end
      end else if (timeout_s) begin
        if (port_r == PORT_DM) begin
          dm_rdata_r <= {DATA_W{1'b0}};
        end else begin
          if_rdata_r <= {DATA_W{1'b0}};
        end
      end
    end
  end

  mem_arb_wdog #(
    .MAX(WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (grant_s),
    .inc    (state_r == WAIT),
    .expired(wdog_exp_s)
  );

  assign mem_en    = mem_en_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign if_done   = if_done_r;
  assign dm_done   = dm_done_r;
  assign err       = err_r;
  assign if_stall  = if_req & ~if_done_r;
  assign dm_stall  = dm_req_s & ~dm_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WDOG_MAX=8) with a delay-programmable memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_rdata;
  logic        if_done, if_stall;
  logic        dm_rd = 1'b0, dm_wr = 1'b0;
  logic [15:0] dm_addr = 16'h0000, dm_wdata = 16'h0000;
  logic [15:0] dm_rdata;
  logic        dm_done, dm_stall;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        err;

  int total = 0;
  int bad   = 0;

  // memory model controls (written by the main thread)
  int          ack_delay = 0;
  logic [15:0] ack_data  = 16'h0000;
  logic        mute      = 1'b0;
  logic        force_ack = 1'b0;
  // memory model state
  logic        busy = 1'b0;
  int          mcnt = 0;
  logic [15:0] alog[$];
  logic        wlog[$];
  logic [15:0] dlog[$];

  // per-run observations
  int   en_n, if_done_n, dm_done_n, if_done_at, dm_done_at;
  logic if_stall_h[0:31];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WDOG_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  // backing memory: acks ack_delay cycles after the mem_en cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy    = 1'b0;
        mem_ack = force_ack;
      end else begin
        if (mem_en) begin
          busy = 1'b1;
          mcnt = 0;
          alog.push_back(mem_addr);
          wlog.push_back(mem_wr);
          dlog.push_back(mem_wdata);
        end else if (busy) begin
          mcnt = mcnt + 1;
        end
        mem_ack   = (busy && !mute && (mcnt == ack_delay)) || force_ack;
        mem_rdata = ack_data;
        if (mem_ack) busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    mute = 1'b0; force_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // run ncyc cycles; a requester drops its request hold cycles after its done
  task automatic run(input int ncyc, input int hold);
    en_n = 0; if_done_n = 0; dm_done_n = 0; if_done_at = -1; dm_done_at = -1;
    alog.delete(); wlog.delete(); dlog.delete();
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (mem_en) en_n = en_n + 1;
      if (if_done) begin
        if_done_n = if_done_n + 1;
        if (if_done_at < 0) if_done_at = c;
      end
      if (dm_done) begin
        dm_done_n = dm_done_n + 1;
        if (dm_done_at < 0) dm_done_at = c;
      end
      if (c < 32) if_stall_h[c] = if_stall;
      if (if_done_at >= 0 && c == if_done_at + hold) if_req = 1'b0;
      if (dm_done_at >= 0 && c == dm_done_at + hold) begin
        dm_rd = 1'b0;
        dm_wr = 1'b0;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset_outputs",
          {if_rdata, dm_rdata}, 32'h0000_0000);
    check("reset_ctrl",
          {23'd0, if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err, mem_addr != 16'h0, mem_wdata != 16'h0},
          32'h0);
    rst = 1'b0;
    tick();

    // fetch only, ack 3 cycles after mem_en
    ack_delay = 3; ack_data = 16'hA5A5;
    if_req = 1'b1; if_addr = 16'h0010;
    run(10, 0);
    check("fetch_en_count", en_n, 1);
    check("fetch_addr", alog[0], 16'h0010);
    check("fetch_done_at", if_done_at, 5);
    check("fetch_done_count", if_done_n, 1);
    check("fetch_rdata", if_rdata, 16'hA5A5);
    check("fetch_stall_c1", if_stall_h[1], 1'b1);
    check("fetch_stall_c4", if_stall_h[4], 1'b1);
    check("fetch_stall_c5", if_stall_h[5], 1'b0);
    check("fetch_err", err, 1'b0);

    // simultaneous requests: data first, then fetch
    ack_delay = 1; ack_data = 16'h5A5A;
    if_req = 1'b1; if_addr = 16'h0020;
    dm_rd = 1'b1; dm_addr = 16'h0200;
    run(12, 0);
    check("simul_en_count", en_n, 2);
    check("simul_first", alog[0], 16'h0200);
    check("simul_second", alog[1], 16'h0020);
    check("simul_dm_done_at", dm_done_at, 3);
    check("simul_if_done_at", if_done_at, 6);
    check("simul_dm_rdata", dm_rdata, 16'h5A5A);

    // store with zero-wait ack; request held through the done cycle
    ack_delay = 0;
    dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    run(8, 1);
    check("store_en_count", en_n, 1);
    check("store_wr", wlog[0], 1'b1);
    check("store_wdata", dlog[0], 16'h1234);
    check("store_addr", alog[0], 16'h0040);
    check("store_done_at", dm_done_at, 2);
    check("store_dm_rdata_kept", dm_rdata, 16'h5A5A);
    check("store_err", err, 1'b0);

    // watchdog: good read first, then a memory that never acks
    do_reset();
    ack_delay = 0; ack_data = 16'h7777;
    dm_rd = 1'b1; dm_addr = 16'h0100;
    run(5, 0);
    check("pre_wdog_rdata", dm_rdata, 16'h7777);
    mute = 1'b1;
    dm_rd = 1'b1; dm_addr = 16'h0102;
    run(14, 0);
    check("wdog_en_count", en_n, 1);
    check("wdog_done_at", dm_done_at, 10);
    check("wdog_done_count", dm_done_n, 1);
    check("wdog_rdata", dm_rdata, 16'h0000);
    check("wdog_err", err, 1'b1);
    mute = 1'b0; ack_data = 16'h1111;
    if_req = 1'b1; if_addr = 16'h0050;
    run(5, 0);
    check("post_wdog_done_at", if_done_at, 2);
    check("post_wdog_rdata", if_rdata, 16'h1111);
    check("post_wdog_err_sticky", err, 1'b1);

    // read and write together
    do_reset();
    check("illegal_err_clear", err, 1'b0);
    dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0060; dm_wdata = 16'hBEEF;
    run(5, 0);
    check("rdwr_wr", wlog[0], 1'b1);
    check("rdwr_wdata", dlog[0], 16'hBEEF);
    check("rdwr_err", err, 1'b1);

    // odd data address
    do_reset();
    ack_data = 16'h4242;
    dm_rd = 1'b1; dm_addr = 16'h0003;
    run(5, 0);
    check("odd_addr", alog[0], 16'h0002);
    check("odd_err", err, 1'b1);
    check("odd_rdata", dm_rdata, 16'h4242);

    // reset while waiting, then a stale ack
    do_reset();
    mute = 1'b1;
    if_req = 1'b1; if_addr = 16'h0030;
    run(4, 0);
    rst = 1'b1; if_req = 1'b0;
    #1;
    check("rst_wait_ctrl",
          {25'd0, if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err}, 32'h0);
    check("rst_wait_addr", mem_addr, 16'h0000);
    tick();
    rst = 1'b0; mute = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    run(4, 0);
    check("stale_ack_if_done", if_done_n, 0);
    check("stale_ack_dm_done", dm_done_n, 0);
    check("stale_ack_en", en_n, 0);
    ack_delay = 2; ack_data = 16'h2222;
    if_req = 1'b1; if_addr = 16'h0032;
    run(8, 0);
    check("after_rst_addr", alog[0], 16'h0032);
    check("after_rst_done_at", if_done_at, 4);
    check("after_rst_rdata", if_rdata, 16'h2222);
    check("after_rst_err", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
